// File: rtl/ref_bank_fill_sched.sv
// Write-side scheduler for the 32-bank reference search-window memory.
// Runs the full 8-group preload, then single-group refills that yield to reads.
module ref_bank_fill_sched #(
    parameter int NUM_GROUPS = 8,
    parameter int LINES      = 96,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              refill_req,
    input  logic [2:0]        refill_group,
    input  logic [7:0]        rd_busy_mask,
    output logic [31:0]       bank_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              preload_done,
    output logic              refill_done,
    output logic              refill_drop,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        READY,
        REFILL
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] line_cnt;
    logic [2:0]        grp_cnt;
    logic [2:0]        tgt;
    logic [2:0]        wr_grp;
    logic              xfer;
    logic              last_line;
    logic              last_grp;

    assign last_line = (line_cnt == ADDR_W'(LINES - 1));
    assign last_grp  = (grp_cnt == 3'(NUM_GROUPS - 1));
    assign xfer      = in_valid && in_ready;
    assign wr_grp    = (state == REFILL) ? tgt : grp_cnt;
    assign busy      = (state == PRELOAD) || (state == REFILL);

    // Reads always win: a refill only moves while its group is idle.
    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            PRELOAD: in_ready = 1'b1;
            REFILL:  in_ready = !rd_busy_mask[tgt];
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = PRELOAD;
            end
            PRELOAD: begin
                if (xfer && last_line && last_grp) state_nx = READY;
            end
            READY: begin
                if (start)           state_nx = PRELOAD;
                else if (refill_req) state_nx = REFILL;
            end
            REFILL: begin
                if (xfer && last_line) state_nx = READY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel     <= '0;
            wr_addr      <= '0;
            wr_en        <= 1'b0;
            preload_done <= 1'b0;
            refill_done  <= 1'b0;
            refill_drop  <= 1'b0;
            line_cnt     <= '0;
            grp_cnt      <= '0;
            tgt          <= '0;
        end else begin
            wr_en       <= xfer;
            refill_done <= 1'b0;
            refill_drop <= refill_req && ((state != READY) || start);
            if (xfer) begin
                bank_sel <= 32'hF << {wr_grp, 2'b00};
                wr_addr  <= line_cnt;
                line_cnt <= last_line ? '0 : line_cnt + ADDR_W'(1);
            end else begin
                bank_sel <= '0;
            end
            if (state == PRELOAD && xfer && last_line) begin
                grp_cnt <= grp_cnt + 3'd1;
                if (last_grp) preload_done <= 1'b1;
            end
            if (state == REFILL && xfer && last_line) refill_done <= 1'b1;
            if ((state == IDLE || state == READY) && start) begin
                line_cnt     <= '0;
                grp_cnt      <= '0;
                preload_done <= 1'b0;
            end else if (state == READY && refill_req) begin
                line_cnt <= '0;
                tgt      <= refill_group;
            end
        end
    end

endmodule

// File: tb/tb_ref_bank_fill_sched.sv
// Scoreboard bench for ref_bank_fill_sched: expected writes are queued when
// stimulus is driven and compared as the write strobes appear.
module tb_ref_bank_fill_sched;

    typedef struct {
        logic [31:0] sel;
        logic [6:0]  addr;
        logic        pd;
        logic        rd;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        refill_req;
    logic [2:0]  refill_group;
    logic [7:0]  rd_busy_mask;
    logic [31:0] bank_sel;
    logic [6:0]  wr_addr;
    logic        wr_en;
    logic        preload_done;
    logic        refill_done;
    logic        refill_drop;
    logic        busy;

    int  n_tests;
    int  n_fail;
    wr_t sb[$];

    ref_bank_fill_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .refill_req   (refill_req),
        .refill_group (refill_group),
        .rd_busy_mask (rd_busy_mask),
        .bank_sel     (bank_sel),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .preload_done (preload_done),
        .refill_done  (refill_done),
        .refill_drop  (refill_drop),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_group(input int g, input logic pd_all,
                              input logic last_pd, input logic last_rd,
                              input int n);
        wr_t e;
        logic [31:0] base;
        base = 32'hF;
        for (int a = 0; a < n; a++) begin
            e.sel  = base << (4 * g);
            e.addr = 7'(a);
            e.pd   = pd_all || (last_pd && a == 95);
            e.rd   = last_rd && a == 95;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, bank_sel, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_wen"}, wr_en, 0);
        chk({tag, "_pd"}, preload_done, 0);
        chk({tag, "_rd"}, refill_done, 0);
        chk({tag, "_drop"}, refill_drop, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, in_ready, 0);
    endtask

    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sel", bank_sel, e.sel);
                chk("addr", 32'(wr_addr), 32'(e.addr));
                chk("pd_wr", preload_done, e.pd);
                chk("rd_wr", refill_done, e.rd);
            end
        end else if (refill_done) begin
            chk("rd_no_wr", refill_done, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        refill_req   = 1'b0;
        refill_group = 3'd0;
        rd_busy_mask = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("idle");

        // Preload, valid held high, with a dropped refill in the middle
        push_group(0, 0, 0, 0, 96);
        for (int g = 1; g < 8; g++) push_group(g, 0, g == 7, 0, 96);
        start    = 1'b1;
        in_valid = 1'b1;
        #1 chk("idle_rdy", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        chk("pre_rdy", in_ready, 1);
        chk("pre_busy", busy, 1);
        for (int c = 0; c < 768; c++) begin
            refill_req = (c == 100);
            @(negedge clk);
            if (c == 100) chk("drop_pre", refill_drop, 1);
            if (c == 101) chk("drop_clr", refill_drop, 0);
            if (c == 766) chk("pd_early", preload_done, 0);
        end
        in_valid = 1'b0;
        chk("pd_set", preload_done, 1);
        chk("ready_busy", busy, 0);
        chk("ready_rdy", in_ready, 0);
        wait_drain();

        // start and refill_req together in READY: start wins
        for (int g = 0; g < 8; g++) push_group(g, 0, g == 7, 0, 96);
        start        = 1'b1;
        refill_req   = 1'b1;
        refill_group = 3'd2;
        @(negedge clk);
        start      = 1'b0;
        refill_req = 1'b0;
        chk("cf_busy", busy, 1);
        chk("cf_drop", refill_drop, 1);
        chk("cf_pd", preload_done, 0);

        // Preload with in_valid toggling every cycle
        for (int c = 0; c < 1536; c++) begin
            in_valid = (c % 2 == 0);
            @(negedge clk);
            if (c < 8) chk("tog_wen", wr_en, (c % 2 == 0));
            if (c == 1533) chk("tog_pd_early", preload_done, 0);
        end
        in_valid = 1'b0;
        chk("tog_pd", preload_done, 1);
        chk("tog_busy", busy, 0);
        wait_drain();

        // Refill group 3, read controller holds it busy at line 40
        push_group(3, 1, 0, 1, 96);
        refill_req   = 1'b1;
        refill_group = 3'd3;
        in_valid     = 1'b1;
        @(negedge clk);
        refill_req = 1'b0;
        chk("rf_busy", busy, 1);
        chk("rf_drop", refill_drop, 0);
        repeat (40) @(negedge clk);
        rd_busy_mask = 8'h08;
        for (int i = 0; i < 10; i++) begin
            #1 chk("stall_rdy", in_ready, 0);
            @(negedge clk);
        end
        rd_busy_mask = 8'hF7;
        #1 chk("resume_rdy", in_ready, 1);
        wait_drain();
        rd_busy_mask = 8'h00;
        in_valid     = 1'b0;
        chk("rf_ready", busy, 0);
        chk("rf_pd", preload_done, 1);

        // Refill group 5, reset lands at line 50
        push_group(5, 1, 0, 0, 50);
        refill_req   = 1'b1;
        refill_group = 3'd5;
        in_valid     = 1'b1;
        @(negedge clk);
        refill_req = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre_rst_sel", bank_sel, 32'h00F00000);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1 chk_reset("mid_rst");
        chk("mid_rst_sb", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        refill_req   = 1'b1;
        refill_group = 3'd1;
        @(negedge clk);
        refill_req = 1'b0;
        chk("idle_drop", refill_drop, 1);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        chk("idle_drop_clr", refill_drop, 0);
        chk("idle_wen", wr_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
